// File: rtl/dynamic_delay_line.sv
// Multi-channel shift-register delay line with a shared shift enable, per-channel
// run-time tap selection, a shared occupancy counter and a per-tap valid qualifier.
module dynamic_delay_line #(
  parameter int    AW      = 4,
  parameter int    DW      = 8,
  parameter int    NCH     = 2,
  parameter string IS_SYNC = "true"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              ce,
  input  logic [NCH*DW-1:0] si,
  input  logic [NCH*AW-1:0] addr,
  output logic [NCH*DW-1:0] so,
  output logic [NCH-1:0]    so_valid
);

  localparam int         DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL    = DEPTH[AW:0];
  localparam bit         SYNC_OUT = (IS_SYNC == "true");

  logic [AW:0] fill_q, fill_d;

  // Occupancy counts shifts since reset/clr and sticks at DEPTH.
  always_comb begin
    fill_d = fill_q;
    if (clr)                    fill_d = '0;
    else if (ce && fill_q != FULL) fill_d = fill_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fill_q <= '0;
    else        fill_q <= fill_d;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DEPTH-1:0][DW-1:0] stage_q, stage_d;
    logic [AW-1:0]            tap_addr;
    logic [DW-1:0]            tap_data;
    logic                     tap_vld;

    assign tap_addr = addr[c*AW +: AW];

    always_comb begin
      stage_d = stage_q;
      if (clr)     stage_d = '0;
      else if (ce) stage_d = {stage_q[DEPTH-2:0], si[c*DW +: DW]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stage_q <= '0;
      else        stage_q <= stage_d;
    end

    // Tap reads the pre-edge stages and fill, so a freshly moved addr is honoured at once.
    assign tap_data = stage_q[tap_addr];
    assign tap_vld  = (fill_q > {1'b0, tap_addr});

    if (SYNC_OUT) begin : g_reg
      logic [DW-1:0] so_q;
      logic          vld_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          so_q  <= '0;
          vld_q <= 1'b0;
        end else begin
          so_q  <= tap_data;
          vld_q <= tap_vld;
        end
      end

      assign so[c*DW +: DW] = so_q;
      assign so_valid[c]    = vld_q;
    end else begin : g_comb
      assign so[c*DW +: DW] = tap_data;
      assign so_valid[c]    = tap_vld;
    end
  end

endmodule

// File: doc/dynamic_delay_line.md
# dynamic_delay_line

Multi-channel, run-time-addressable shift-register delay line with per-channel tap selection, occupancy tracking and a tap-valid flag. It is the next generation of the single-channel dynamic shift register. It adds async reset, synchronous clear, NCH independent taps, and a qualifier that marks when the selected tap holds real shifted-in data rather than reset fill. Typical uses are alignment of parallel data lanes and programmable pipeline balancing in DSP datapaths.

## Interface
Parameters:
- AW, 4, tap address width; depth DEPTH = 2**AW stages per channel (AW ≥ 1)
- DW, 8, data width per channel
- NCH, 2, channel count (≥ 1); all channels share one shift enable
- IS_SYNC, "true", "true" gives registered outputs; any other value gives combinational outputs

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of storage and occupancy
- ce  in  1  shift enable; shifts every channel one stage
- si  in  NCH*DW  shift-in data; channel c is bits [c*DW +: DW]
- addr  in  NCH*AW  per-channel tap index; channel c is bits [c*AW +: AW]; 0 is the newest stage
- so  out  NCH*DW  tap data, channel c is bits [c*DW +: DW]
- so_valid  out  NCH  per-channel tap-valid flag

## Operation
- Storage: NCH × DEPTH × DW registers.
- On ce, for each channel: stage 0 loads si[c], and stage i loads stage i-1 for i = 1..DEPTH-1.
- Occupancy counter `fill`, width AW+1:
  - counts ce pulses since the last reset or clr;
  - saturates at DEPTH, with no wrap.
- Tap read per channel:
  - tap data = stage[addr[c]], read from the pre-edge contents;
  - tap valid = (fill > addr[c]), using the pre-edge fill.
- clr:
  - zeroes all stages and sets fill = 0 on the next edge;
  - clr has priority over ce, so si is discarded when both are high.
- Reset (rst_n low, asynchronous) clears:
  - all stages;
  - fill;
  - so = 0;
  - so_valid = 0.
- Reset release is synchronous: the first state change may occur at the first clk edge with rst_n high.
- addr may change on any cycle. There is no flush or hold: the new tap is read immediately and so_valid is re-evaluated against fill.
- Channels are independent except for the shared ce, clr and fill.

## Timing
- IS_SYNC = "true":
  - so and so_valid are registered and show the tap state at edge k at edge k+1;
  - latency from si sampled at edge k to so is (addr+1) ce pulses plus 1 clk.
- IS_SYNC ≠ "true":
  - so and so_valid are combinational from addr, the stages and fill;
  - they are valid in the same cycle;
  - latency is addr+1 ce pulses.
- Sync mode, clr at edge k: the edge k+1 output reflects the cleared state, i.e. so = 0 and so_valid = 0.
- The registered output path is updated every clk regardless of ce; ce gates only the shift.
- Boundary conditions:
  - addr = DEPTH-1 becomes valid only after DEPTH ce pulses;
  - at fill = DEPTH, further ce keeps fill at DEPTH and the oldest data is dropped;
  - ce held low freezes the stages and fill indefinitely.
- Reset mid-operation: all outputs go to 0 immediately, without waiting for a clk edge.

## Test plan
- Reset (AW=4, DW=8, NCH=2, sync), with rst_n asserted mid-stream:
  - so and so_valid go to 0 before the next clk edge;
  - after release with ce = 0, so = 0 and so_valid = 0 hold.
- Fixed delay: addr = {4'd3, 4'd0}, ce = 1 continuously, si ch0 = 1,2,3…, ch1 = 8'hA0+n:
  - ch0: so = 1 appears 2 clk after the first sample, so_valid rises with it;
  - ch1: data from 4 shifts earlier; so_valid rises on the 5th output clk.
- Gated ce: ce toggles 1,0,1,0 with addr = 2:
  - delay counts only ce pulses;
  - so holds steady while ce = 0;
  - so_valid rises after the 3rd ce.
- Saturation and wrap: 20 ce pulses with addr = 15:
  - fill saturates at 16;
  - so equals the sample from 16 shifts earlier;
  - so_valid remains 1.
- clr priority: clr and ce both high with si = 8'h55:
  - next output so = 0, so_valid = 0;
  - 8'h55 never appears at any tap;
  - after one more ce, addr = 0 is valid.
- Async mode (IS_SYNC = "false"):
  - changing addr from 0 to 5 with fill = 3 changes so in the same cycle to stage 5's content (0);
  - so_valid drops to 0 combinationally.
